// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the bit-serial ALU controller.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_SLT  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_OR   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
   endfunction

   // SUB and SLT compute a + ~b + 1
   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit combinational ALU slice; the serial controller feeds it one operand bit per cycle.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a_bit,
   input  logic       b_bit,
   input  logic       carry_in,
   input  logic [2:0] op,
   output logic       res_bit,
   output logic       carry_out
);

   logic w_b;

   assign w_b = b_bit ^ is_sub(op);

   always_comb begin
      res_bit   = 1'b0;
      carry_out = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_SLT: begin
            res_bit   = a_bit ^ w_b ^ carry_in;
            carry_out = (a_bit & w_b) | (a_bit & carry_in) | (w_b & carry_in);
         end
         OP_XOR:  res_bit = a_bit ^ b_bit;
         OP_AND:  res_bit = a_bit & b_bit;
         OP_NAND: res_bit = ~(a_bit & b_bit);
         OP_NOR:  res_bit = ~(a_bit | b_bit);
         OP_OR:   res_bit = a_bit | b_bit;
         default: res_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one operand bit per cycle, LSB first.
// Define ALU_SERIAL_CTRL_OVF_EN to drive the overflow output; otherwise it is tied to 0.
//
// state   | meaning
// IDLE    | waiting for start, last results held
// RUN     | processing bit r_cnt of the latched operands
// DONE    | one-cycle completion pulse; start here begins a new run
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             overflow
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sh;
   logic             r_c;
   logic             r_zacc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;

   logic             w_accept;
   logic             w_last;
   logic             w_res_bit;
   logic             w_cout;
   logic             w_ovf;
   logic             w_slt;
   logic             w_arith;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_final;

   alu_bit_slice u_slice (
      .a_bit     (r_a[0]),
      .b_bit     (r_b[0]),
      .carry_in  (r_c),
      .op        (r_op),
      .res_bit   (w_res_bit),
      .carry_out (w_cout)
   );

   assign w_accept = start && (r_state != ST_RUN);
   assign w_last   = (r_cnt == LAST);
   assign w_arith  = is_arith(r_op);
   assign w_sum    = {w_res_bit, r_sh[WIDTH-1:1]};
   // On the MSB cycle r_c is the carry into the sign bit
   assign w_ovf    = r_c ^ w_cout;
   assign w_slt    = w_res_bit ^ w_ovf;
   assign w_final  = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_slt} : w_sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_op     <= OP_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_sh     <= '0;
         r_c      <= 1'b0;
         r_zacc   <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  r_state <= ST_RUN;
                  r_op    <= op;
                  r_a     <= a;
                  r_b     <= b;
                  r_sh    <= '0;
                  r_c     <= is_sub(op);
                  r_zacc  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a    <= {1'b0, r_a[WIDTH-1:1]};
               r_b    <= {1'b0, r_b[WIDTH-1:1]};
               r_sh   <= w_sum;
               r_c    <= w_cout;
               r_zacc <= r_zacc | w_res_bit;
               if (w_last) begin
                  r_state  <= ST_DONE;
                  r_result <= w_final;
                  r_carry  <= w_arith & w_cout;
                  r_zero   <= (r_op == OP_SLT) ? ~w_slt : ~(r_zacc | w_res_bit);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_SERIAL_CTRL_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk) begin
      if (reset)
         r_ovf <= 1'b0;
      else if ((r_state == ST_RUN) && w_last)
         r_ovf <= w_arith & w_ovf;
   end

   assign overflow = r_ovf;
`else
   assign overflow = 1'b0;
`endif

   assign busy   = (r_state == ST_RUN);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;
   assign carry  = r_carry;
   assign zero   = r_zero;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl at WIDTH=32.
module tb_alu_serial_ctrl;
   import alu_pkg::*;

   localparam int W     = 32;
   localparam int LIMIT = 100;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry;
   logic         zero;
   logic         overflow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         v;
   } vec_t;

   vec_t vecs[13];

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .carry    (carry),
      .zero     (zero),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic exp_ovf(input logic v);
`ifdef ALU_SERIAL_CTRL_OVF_EN
      return v;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts cycles from the first sample after the start edge (lat=1) until done
   task automatic wait_done(output int lat, output int busy_err, input bit pulse_ign);
      lat      = 1;
      busy_err = 0;
      while (!done && lat < LIMIT) begin
         if (!busy) busy_err++;
         if (pulse_ign && (lat == 5 || lat == 20)) begin
            start = 1'b1;
            op    = OP_OR;
            a     = '0;
            b     = '0;
         end else begin
            start = 1'b0;
         end
         tick();
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"},   busy,     1'b0);
      chk({tag, "_done"},   done,     1'b0);
      chk({tag, "_result"}, result,   '0);
      chk({tag, "_carry"},  carry,    1'b0);
      chk({tag, "_zero"},   zero,     1'b0);
      chk({tag, "_ovf"},    overflow, 1'b0);
   endtask

   initial begin
      int lat;
      int berr;
      int extra;

      vecs[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{OP_AND,  32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{OP_NOR,  32'h0F0F0000, 32'h00F0F000, 32'hF0000FFF, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{OP_OR,   32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{OP_SUB,  32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};

      reset = 1'b1;
      start = 1'b0;
      op    = OP_ADD;
      a     = '0;
      b     = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk_cleared("reset");

      for (int i = 0; i < 13; i++) begin
         kick(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(lat, berr, 1'b0);
         chk($sformatf("v%0d_latency", i), lat, 33);
         chk($sformatf("v%0d_busy", i), berr, 0);
         chk($sformatf("v%0d_result", i), result, vecs[i].res);
         chk($sformatf("v%0d_carry", i), carry, vecs[i].c);
         chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
         chk($sformatf("v%0d_ovf", i), overflow, exp_ovf(vecs[i].v));
         tick();
         chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
         chk($sformatf("v%0d_hold", i), result, vecs[i].res);
      end

      // start while busy must be ignored
      kick(OP_NAND, 32'hAAAA5555, 32'h0F0F0F0F);
      wait_done(lat, berr, 1'b1);
      chk("ign_latency", lat, 33);
      chk("ign_busy", berr, 0);
      chk("ign_result", result, 32'hF5F5FAFA);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) extra++;
      end
      chk("ign_single_done", extra, 0);
      chk("ign_hold", result, 32'hF5F5FAFA);

      // reset while bit 10 of an OR run is being processed
      kick(OP_OR, 32'h00FF0000, 32'h0000FF00);
      repeat (10) tick();
      chk("mid_busy", busy, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_cleared("mid_reset");
      kick(OP_OR, 32'h00FF0000, 32'h0000FF00);
      wait_done(lat, berr, 1'b0);
      chk("post_reset_latency", lat, 33);
      chk("post_reset_result", result, 32'h00FFFF00);

      // reset wins over a simultaneous start
      op    = OP_ADD;
      a     = 32'h1;
      b     = 32'h1;
      start = 1'b1;
      reset = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      chk_cleared("rst_prio");
      tick();
      chk("rst_prio_idle", busy, 1'b0);

      // back-to-back start in the DONE cycle
      kick(OP_ADD, 32'd10, 32'd20);
      wait_done(lat, berr, 1'b0);
      chk("b2b_first_latency", lat, 33);
      chk("b2b_first_result", result, 32'd30);
      kick(OP_SUB, 32'd100, 32'd1);
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_done_low", done, 1'b0);
      chk("b2b_held", result, 32'd30);
      wait_done(lat, berr, 1'b0);
      chk("b2b_second_latency", lat, 33);
      chk("b2b_second_result", result, 32'd99);
      chk("b2b_second_carry", carry, 1'b1);
      chk("b2b_second_zero", zero, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 SLT, 011 XOR, 100 AND, 101 NAND, 110 NOR, 111 OR.
REQ-006 SHALL have ports a, b  input  WIDTH  operands, two's complement.
REQ-007 SHALL have port busy  output  1  operation in progress.
REQ-008 SHALL have port done  output  1  single-cycle completion pulse.
REQ-009 SHALL have port result  output  WIDTH  operation result.
REQ-010 SHALL have ports carry, zero, overflow  output  1  each: carry-out of final bit, result==0, signed overflow.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after WIDTH RUN cycles, DONE->RUN on start else DONE->IDLE.
REQ-012 SHALL accept start only when busy==0 (IDLE or DONE), latching a, b, op on that edge; start while busy SHALL be ignored with no effect.
REQ-013 SHALL process one bit per RUN cycle, LSB first, using a bit counter 0..WIDTH-1 with no wrap beyond WIDTH-1.
REQ-014 SHALL, per bit, invert b and seed carry-in=1 for SUB/SLT; carry-in=0 for ADD; logic ops ignore carry chain.
REQ-015 SHALL accumulate the zero flag as OR-chain of result bits, cleared at start; zero=1 iff final result all zeros.
REQ-016 SHALL, for SLT, output result={WIDTH-1 zeros, sign(a-b) XOR signed overflow}; zero reflects this final result.
REQ-017 SHALL drive carry=final carry-out for ADD/SUB/SLT, 0 for logic ops.
REQ-018 SHALL have latency: start sampled at edge k -> busy=1 cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1 only.
REQ-019 SHALL hold result/carry/zero/overflow stable from done until the next accepted start; undefined-free (no X) at all times after reset.

Reset
REQ-020 SHALL, on reset at any time including mid-RUN, enter IDLE and clear busy, done, result, carry, zero, overflow and bit counter to 0 on the next edge.
REQ-021 SHALL give reset priority over a simultaneous start.

Configuration
REQ-022 SHALL honour macro ALU_SERIAL_CTRL_OVF_EN: defined -> overflow = carry-in XOR carry-out of MSB for ADD/SUB/SLT, 0 for logic ops.
REQ-023 SHALL, without ALU_SERIAL_CTRL_OVF_EN, keep the overflow port but tie it to 0; SLT SHALL still use internal overflow correction.

Structure
REQ-024 SHALL place opcode constants (OP_ADD..OP_OR) and FSM state encodings in shared package alu_pkg.
REQ-025 SHALL instantiate one combinational sub-module alu_bit_slice (inputs a_bit, b_bit, carry_in, op; outputs res_bit, carry_out); all state lives in alu_serial_ctrl.

Verification (WIDTH=32)
REQ-026 SHALL cover ADD 0xFFFFFFFF+0x00000001 -> result 0x00000000, carry 1, zero 1, done exactly 33 cycles after start edge.
REQ-027 SHALL cover SUB 5-7 -> result 0xFFFFFFFE, carry 0, zero 0; SLT a=0xFFFFFFFF b=0x00000001 -> result 0x00000001.
REQ-028 SHALL cover ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow 1 with macro, 0 without.
REQ-029 SHALL cover start re-asserted at cycles k+5 and k+20 of a NAND run -> ignored, single done, result = ~(a&b) of first operands.
REQ-030 SHALL cover reset at bit 10 of an OR run -> next cycle IDLE, all outputs 0; new start then completes normally in 33 cycles.
REQ-031 SHALL cover back-to-back: start asserted in DONE cycle -> new run accepted, busy next cycle, prior result held until then.
